slot_ctrl: RTL and testbench
============================

Name: slot_ctrl

Overview:
- Sequencing controller for a three-reel slot game built from the enable_gen / counter10_en / decimal_decoder datapath.
- Starts all reels on a start press and stops each reel on its own stop press, once a minimum spin time has passed.
- After the last reel stops, judges the three digits, then holds the result for a fixed time.
- Drives the per-reel count enables and win/lamp outputs; the top level wires o_reel_run[k] AND the shared 1 Hz tick into each reel counter's i_en.

Parameters:
- MIN_TICKS, 3, ticks after start during which stop presses are ignored (>=1).
- HOLD_TICKS, 5, ticks the RESULT state lasts before returning to IDLE (>=1).

Ports:
- clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  one-cycle pulse from enable_gen (approx. 1 Hz).
- i_start  in  1  start button level, already synchronised to clk.
- i_stop  in  3  stop button levels, bit k = reel k, already synchronised.
- i_reel0, i_reel1, i_reel2  in  4 each  current reel digits, 0-9.
- o_reel_run  out  3  bit k high = reel k counts.
- o_busy  out  1  high in SPIN and JUDGE.
- o_win  out  1  high in RESULT when all three digits are equal.
- o_lamp  out  1  win lamp; toggles on every i_tick in RESULT when the spin is a win, otherwise low.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, o_reel_run=000, o_busy=0, o_win=0, o_lamp=0, tick counter=0, edge-detect history registers=0.
- All outputs are registered.
- Edge detection: a press is a 0->1 transition of i_start or i_stop[k], compared against the previous-cycle level. Holding a button produces exactly one press.
- Pressing a button on the first cycle after reset counts as an edge.
- States: IDLE, SPIN, JUDGE, RESULT.
- IDLE:
  - Start press -> SPIN next cycle: o_reel_run=111, o_busy=1, tick counter cleared.
  - Stop presses are ignored.
- SPIN:
  - The tick counter increments on each i_tick and saturates at MIN_TICKS.
  - A stop press on bit k is honoured only if the counter equals MIN_TICKS and o_reel_run[k]=1. It clears o_reel_run[k] on the next cycle (stop at cycle N -> run bit low at N+1).
  - Several stop presses in the same cycle all take effect together.
  - Presses for already-stopped reels are ignored.
  - Start presses are ignored.
  - When the last running bit clears (o_reel_run becomes 000), go to JUDGE on that same registered update.
- JUDGE, one cycle:
  - win = (i_reel0==i_reel1) && (i_reel1==i_reel2). The reels are frozen, so the inputs are stable.
  - Next cycle: RESULT, o_win=win, o_busy=0, o_lamp=win, tick counter cleared.
  - Last stop at cycle N -> JUDGE at N+1 -> o_win valid at N+2.
- RESULT:
  - The counter increments on i_tick. On win, o_lamp toggles on each i_tick.
  - When the counter reaches HOLD_TICKS -> IDLE: o_win=0, o_lamp=0.
  - A start press in RESULT aborts the hold and goes straight to SPIN with o_win=0, o_lamp=0, o_reel_run=111 (restart priority).
- Simultaneous events:
  - Start and stop presses in IDLE on the same cycle: start is taken, stops discarded.
  - An i_tick on the same cycle as the transition into SPIN or RESULT is not counted.
- Reset mid-operation: immediate return to the reset values. Reel counters are not cleared by this block.
- Counter width: $clog2(max(MIN_TICKS,HOLD_TICKS)+1) bits, with no wrap (it saturates or exits before wrapping).

Decomposition:
- Package slot_pkg: state encoding constants (IDLE=2'd0, SPIN=2'd1, JUDGE=2'd2, RESULT=2'd3) and NUM_REELS=3.
- Sub-module edge_detect (rising-edge, parameter WIDTH), instantiated once for {i_start, i_stop}. The FSM, tick counter and judge logic stay in slot_ctrl.

Test Plan:
- Reset with buttons idle -> all outputs 0 and state IDLE; assert i_rst_n=0 mid-SPIN -> o_reel_run=000 and o_busy=0 asynchronously.
- Start press, then stop[0] after 1 tick (MIN_TICKS=3) -> o_reel_run stays 111; stop[0] after 3 ticks -> o_reel_run=110 one cycle later.
- Reels at 7,7,7, stops pressed one at a time in order 2,0,1 -> o_reel_run goes 011, 010, 000; o_win=1 two cycles after the last stop; o_lamp toggles on each of 5 ticks, then IDLE with o_win=0.
- Reels at 3,3,4 with all three stops pressed in the same cycle -> o_reel_run=000 next cycle; o_win=0 and o_lamp=0 throughout RESULT; IDLE after 5 ticks.
- stop[1] held high for 10 cycles and start held high across SPIN -> only one stop honoured and no restart.
- Start press in the 2nd tick of a winning RESULT -> o_win=0, o_reel_run=111 on the next cycle.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the three-reel slot sequencer.
package slot_pkg;

  localparam int unsigned NUM_REELS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    JUDGE  = 2'd2,
    RESULT = 2'd3
  } slot_state_e;

endpackage

// File: rtl/slot_ctrl_edge_detect.sv
// Rising-edge detector: one-cycle pulse per 0->1 transition of each input bit.
module edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] level_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) level_q <= '0;
    else          level_q <= i_level;
  end

  // History resets low, so a button already held at reset release counts as a press.
  assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/slot_ctrl.sv
// Slot game sequencer: starts all reels, stops each on its own button after a
// minimum spin time, judges the digits and holds the result with a blinking lamp.
module slot_ctrl
  import slot_pkg::*;
#(
  parameter int MIN_TICKS  = 3,
  parameter int HOLD_TICKS = 5
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_start,
  input  logic [NUM_REELS-1:0] i_stop,
  input  logic [3:0]           i_reel0,
  input  logic [3:0]           i_reel1,
  input  logic [3:0]           i_reel2,
  output logic [NUM_REELS-1:0] o_reel_run,
  output logic                 o_busy,
  output logic                 o_win,
  output logic                 o_lamp
);

  localparam int CNT_MAX = (MIN_TICKS > HOLD_TICKS) ? MIN_TICKS : HOLD_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_TICKS);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_TICKS);

  slot_state_e          state_q, state_d;
  logic [NUM_REELS-1:0] run_q, run_d;
  logic                 busy_q, busy_d;
  logic                 win_q, win_d;
  logic                 lamp_q, lamp_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [NUM_REELS:0]   rise;
  logic                 start_press;
  logic [NUM_REELS-1:0] stop_press;
  logic [NUM_REELS-1:0] run_left;
  logic                 reels_match;

  edge_detect #(.WIDTH(NUM_REELS + 1)) u_edge (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_level ({i_start, i_stop}),
    .o_rise  (rise)
  );

  assign start_press = rise[NUM_REELS];
  assign stop_press  = rise[NUM_REELS-1:0];
  assign reels_match = (i_reel0 == i_reel1) && (i_reel1 == i_reel2);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lamp_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lamp_q  <= lamp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    busy_d   = busy_q;
    win_d    = win_q;
    lamp_d   = lamp_q;
    cnt_d    = cnt_q;
    run_left = run_q & ~stop_press;
    unique case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d = SPIN;
          run_d   = '1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      SPIN: begin
        if (i_tick && (cnt_q != MIN_C)) cnt_d = cnt_q + CW'(1);
        // Eligibility uses the pre-tick count, so a stop on the MIN-th tick cycle is ignored.
        if (cnt_q == MIN_C) begin
          run_d = run_left;
          if (run_left == '0) state_d = JUDGE;
        end
      end
      JUDGE: begin
        state_d = RESULT;
        busy_d  = 1'b0;
        win_d   = reels_match;
        lamp_d  = reels_match;
        cnt_d   = '0;
      end
      RESULT: begin
        if (start_press) begin
          state_d = SPIN;
          run_d   = '1;
          busy_d  = 1'b1;
          win_d   = 1'b0;
          lamp_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_C) begin
          state_d = IDLE;
          win_d   = 1'b0;
          lamp_d  = 1'b0;
        end else if (i_tick) begin
          cnt_d = cnt_q + CW'(1);
          if (win_q) lamp_d = ~lamp_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_reel_run = run_q;
  assign o_busy     = busy_q;
  assign o_win      = win_q;
  assign o_lamp     = lamp_q;

endmodule

// File: tb/tb_slot_ctrl.sv
// Bench for slot_ctrl: directed scenarios with literal expectations plus random
// stimulus, all checked every cycle against a behavioural game model.
module tb_slot_ctrl;

  localparam int MIN  = 3;
  localparam int HOLD = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_l = 1'b0;
  logic       start_l = 1'b0;
  logic [2:0] stop_l = '0;
  logic [3:0] reel0 = '0, reel1 = '0, reel2 = '0;
  logic [2:0] run;
  logic       busy, win, lamp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  slot_ctrl #(.MIN_TICKS(MIN), .HOLD_TICKS(HOLD)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_tick     (tick_l),
    .i_start    (start_l),
    .i_stop     (stop_l),
    .i_reel0    (reel0),
    .i_reel1    (reel1),
    .i_reel2    (reel2),
    .o_reel_run (run),
    .o_busy     (busy),
    .o_win      (win),
    .o_lamp     (lamp)
  );

  // Behavioural model: game phase flags, which reels the player has stopped,
  // ticks seen in the current phase; lamp follows tick parity on a win.
  bit       m_spin, m_judge, m_show, m_win;
  bit [2:0] m_stopped;
  int       m_ticks;
  bit       p_start;
  bit [2:0] p_stop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_spin = 0; m_judge = 0; m_show = 0; m_win = 0;
      m_stopped = '0; m_ticks = 0; p_start = 0; p_stop = '0;
    end else begin
      bit       sp;
      bit [2:0] stp;
      bit       eligible;
      sp  = start_l && !p_start;
      stp = stop_l & ~p_stop;
      p_start = start_l;
      p_stop  = stop_l;
      if (m_spin) begin
        eligible = (m_ticks >= MIN);
        if (tick_l && m_ticks < MIN) m_ticks++;
        for (int k = 0; k < 3; k++)
          if (eligible && stp[k]) m_stopped[k] = 1;
        if (m_stopped == 3'b111) begin m_spin = 0; m_judge = 1; end
      end else if (m_judge) begin
        m_win = (reel0 == reel1) && (reel1 == reel2);
        m_judge = 0; m_show = 1; m_ticks = 0;
      end else if (m_show) begin
        if (sp) begin
          m_show = 0; m_spin = 1; m_stopped = '0; m_ticks = 0;
        end else if (m_ticks == HOLD) begin
          m_show = 0;
        end else if (tick_l) begin
          m_ticks++;
        end
      end else if (sp) begin
        m_spin = 1; m_stopped = '0; m_ticks = 0;
      end
    end
  end

  function automatic logic [5:0] dut_vec();
    return {run, busy, win, lamp};
  endfunction

  function automatic logic [5:0] model_vec();
    logic [2:0] r;
    r = m_spin ? ~m_stopped : 3'b000;
    return {r, logic'(m_spin || m_judge), logic'(m_show && m_win),
            logic'(m_show && m_win && (m_ticks % 2 == 0))};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: run/busy/win/lamp got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) check("cycle", dut_vec(), model_vec());

  task automatic step(input logic s, input logic [2:0] p, input logic t);
    start_l = s; stop_l = p; tick_l = t;
    @(posedge clk);
    #2;
  endtask

  task automatic set_reels(input int a, input int b, input int c);
    reel0 = 4'(a); reel1 = 4'(b); reel2 = 4'(c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", dut_vec(), 6'b000_0_0_0);
    rst_n = 1'b1;

    // Winning spin, stops in order 2,0,1; early stop[0] ignored.
    set_reels(7, 7, 7);
    step(1, 3'b000, 0);
    check("start_spin", dut_vec(), 6'b111_1_0_0);
    step(0, 3'b000, 1);
    step(0, 3'b001, 0);
    check("early_stop", dut_vec(), 6'b111_1_0_0);
    step(0, 3'b000, 1);
    step(0, 3'b000, 1);
    step(0, 3'b100, 0);
    check("stop2", dut_vec(), 6'b011_1_0_0);
    step(0, 3'b000, 0);
    step(0, 3'b001, 0);
    check("stop0", dut_vec(), 6'b010_1_0_0);
    step(0, 3'b000, 0);
    step(0, 3'b010, 0);
    check("judge", dut_vec(), 6'b000_1_0_0);
    step(0, 3'b000, 0);
    check("win_result", dut_vec(), 6'b000_0_1_1);
    for (int i = 1; i <= HOLD; i++) begin
      step(0, 3'b000, 1);
      check("lamp_toggle", dut_vec(), {5'b000_0_1, logic'(i % 2 == 0)});
    end
    step(0, 3'b000, 0);
    check("win_idle", dut_vec(), 6'b000_0_0_0);

    // Losing spin, all stops together.
    set_reels(3, 3, 4);
    step(1, 3'b000, 0);
    step(0, 3'b000, 1);
    step(0, 3'b000, 1);
    step(0, 3'b000, 1);
    step(0, 3'b111, 0);
    check("all_stop", dut_vec(), 6'b000_1_0_0);
    step(0, 3'b000, 0);
    check("lose_result", dut_vec(), 6'b000_0_0_0);
    for (int i = 0; i < HOLD; i++) step(0, 3'b000, 1);
    step(0, 3'b000, 0);
    check("lose_idle", dut_vec(), 6'b000_0_0_0);

    // Held buttons: one stop honoured, no restart from held start.
    step(1, 3'b000, 0);
    for (int i = 0; i < MIN; i++) step(1, 3'b000, 1);
    for (int i = 0; i < 10; i++) step(1, 3'b010, 0);
    check("held_stop", dut_vec(), 6'b101_1_0_0);
    step(1, 3'b000, 0);
    step(1, 3'b101, 0);
    step(1, 3'b000, 0);
    check("held_start_result", dut_vec(), 6'b000_0_0_0);
    for (int i = 0; i < HOLD; i++) step(0, 3'b000, 1);
    step(0, 3'b000, 0);

    // Restart on the second tick of a winning hold, then async reset mid-spin.
    set_reels(5, 5, 5);
    step(1, 3'b000, 0);
    for (int i = 0; i < MIN; i++) step(0, 3'b000, 1);
    step(0, 3'b111, 0);
    step(0, 3'b000, 0);
    step(0, 3'b000, 1);
    check("hold_tick1", dut_vec(), 6'b000_0_1_0);
    step(1, 3'b000, 1);
    check("restart", dut_vec(), 6'b111_1_0_0);
    #1 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), 6'b000_0_0_0);
    start_l = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Random play.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step(0, 3'b000, 0);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        int d;
        d = $urandom_range(0, 9);
        set_reels(d, d, d);
      end else begin
        set_reels($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      end
      step($urandom_range(0, 7) == 0,
           {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
           $urandom_range(0, 2) == 0);
    end

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
